csa_product_resolver: RTL



---
 rtl/csa_product_resolver.sv | 106 ++++++++++
 1 files changed

// File: rtl/csa_product_resolver.sv
// Resolves the multiplier's carry-save (sum, carry) pair into a binary product,
// one SEG_WIDTH-bit segment per cycle, and derives norm/sticky/err for rounding.
module csa_product_resolver #(
  parameter int unsigned SIG_WIDTH = 52,
  parameter int unsigned SEG_WIDTH = 28,
  localparam int unsigned W = 2 * (SIG_WIDTH + 1) + 5,
  localparam int unsigned P = 2 * (SIG_WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum,
  input  logic [W-1:0] carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] product,
  output logic         norm,
  output logic         sticky,
  output logic         err
);

  localparam int unsigned NSEG = (W + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int unsigned PW   = NSEG * SEG_WIDTH;
  localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_q;
  logic [PW-1:0]     sum_q;
  logic [PW-1:0]     carry_q;
  logic [PW-1:0]     res_q;
  logic [PW-1:0]     res_nxt;
  logic [CW-1:0]     seg_q;
  logic              cflop_q;
  logic [SEG_WIDTH:0] seg_sum;
  int unsigned       seg_base;

  // One segment of the ripple: current slices plus the carry held from below.
  always_comb begin
    seg_base = 32'(seg_q) * SEG_WIDTH;
    seg_sum  = {1'b0, sum_q[seg_base +: SEG_WIDTH]}
             + {1'b0, carry_q[seg_base +: SEG_WIDTH]}
             + (SEG_WIDTH + 1)'(cflop_q);
    res_nxt  = res_q;
    res_nxt[seg_base +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      norm      <= 1'b0;
      sticky    <= 1'b0;
      err       <= 1'b0;
      seg_q     <= '0;
      cflop_q   <= 1'b0;
      sum_q     <= '0;
      carry_q   <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q    <= PW'(sum);
            carry_q  <= PW'(carry);
            cflop_q  <= 1'b0;
            seg_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= ADD;
          end
        end
        ADD: begin
          res_q   <= res_nxt;
          cflop_q <= seg_sum[SEG_WIDTH];
          seg_q   <= seg_q + CW'(1);
          if (seg_q == CW'(NSEG - 1)) begin
            // Top segment carry-out and pad bits fall outside the mod-2^W result.
            product   <= res_nxt[P-1:0];
            norm      <= res_nxt[P-1];
            sticky    <= res_nxt[P-1] ? |res_nxt[SIG_WIDTH-1:0]
                                      : |res_nxt[SIG_WIDTH-2:0];
            err       <= |res_nxt[W-1:P];
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
